ex_mem_reg: RTL

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg -- EX/MEM pipeline register.
//
// Captures the EX-stage instruction into the MEM stage each rising edge.
// Update priority: flush > stall > capture. A capture of a non-valid or
// illegal instruction loads a bubble; an illegal capture also sets the
// sticky err_illegal flag, which only reset clears. Writes to r0 are
// suppressed at capture time. EX_MEM_FwdData selects the JAL link address
// or the ALU result, purely from registered state.
//
// Optional feature macro: EX_MEM_PERF_CNT_EN
//   adds saturating 16-bit stall_cnt / flush_cnt event counters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        pipeline hold / bubble insertion
//   ex_*                EX-stage instruction fields and control bits
//   EX_MEM_*            registered MEM-stage copies, plus EX_MEM_FwdData
//   err_illegal         sticky illegal-control-combination flag
//   stall_cnt/flush_cnt (EX_MEM_PERF_CNT_EN only) event counters
// ---------------------------------------------------------------------------
module ex_mem_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_write_data,
   input  logic [31:0] ex_pc_plus4,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [1:0]  ex_mem_to_reg,
   output logic        EX_MEM_valid,
   output logic        EX_MEM_RegWrite,
   output logic        EX_MEM_MemRead,
   output logic        EX_MEM_MemWrite,
   output logic [1:0]  EX_MEM_MemtoReg,
   output logic [31:0] EX_MEM_ALUResult,
   output logic [31:0] EX_MEM_WriteData,
   output logic [31:0] EX_MEM_PCPlus4,
   output logic [4:0]  EX_MEM_Rd,
   output logic [31:0] EX_MEM_FwdData,
   output logic        err_illegal
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   logic illegal;

   // Read+write together, reserved writeback select, or a memory writeback
   // without a load are all nonsensical for a real instruction.
   always_comb begin
      illegal = ex_valid &
                ((ex_mem_read & ex_mem_write) |
                 (ex_mem_to_reg == 2'b11) |
                 ((ex_mem_to_reg == 2'b01) & ~ex_mem_read));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EX_MEM_valid     <= 1'b0;
         EX_MEM_RegWrite  <= 1'b0;
         EX_MEM_MemRead   <= 1'b0;
         EX_MEM_MemWrite  <= 1'b0;
         EX_MEM_MemtoReg  <= 2'b00;
         EX_MEM_ALUResult <= '0;
         EX_MEM_WriteData <= '0;
         EX_MEM_PCPlus4   <= '0;
         EX_MEM_Rd        <= '0;
         err_illegal      <= 1'b0;
      end else if (flush || (!stall && (!ex_valid || illegal))) begin
         // Bubble: explicit flush, a non-valid capture, or a rejected
         // illegal capture.
         EX_MEM_valid     <= 1'b0;
         EX_MEM_RegWrite  <= 1'b0;
         EX_MEM_MemRead   <= 1'b0;
         EX_MEM_MemWrite  <= 1'b0;
         EX_MEM_MemtoReg  <= 2'b00;
         EX_MEM_ALUResult <= '0;
         EX_MEM_WriteData <= '0;
         EX_MEM_PCPlus4   <= '0;
         EX_MEM_Rd        <= '0;
         if (!flush && illegal) begin
            err_illegal <= 1'b1;
         end
      end else if (!stall) begin
         EX_MEM_valid     <= 1'b1;
         EX_MEM_RegWrite  <= ex_reg_write & (ex_rd != 5'd0);
         EX_MEM_MemRead   <= ex_mem_read;
         EX_MEM_MemWrite  <= ex_mem_write;
         EX_MEM_MemtoReg  <= ex_mem_to_reg;
         EX_MEM_ALUResult <= ex_alu_result;
         EX_MEM_WriteData <= ex_write_data;
         EX_MEM_PCPlus4   <= ex_pc_plus4;
         EX_MEM_Rd        <= ex_rd;
      end
   end

   always_comb begin
      EX_MEM_FwdData = (EX_MEM_MemtoReg == 2'b10) ? EX_MEM_PCPlus4 : EX_MEM_ALUResult;
   end

`ifdef EX_MEM_PERF_CNT_EN
   // A combined stall+flush edge counts as a flush only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush) begin
         if (flush_cnt != '1) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end else if (stall) begin
         if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
